// File: rtl/ll_rx_push_ctl.sv
// ---------------------------------------------------------------------------
// ll_rx_push_ctl
//
// Receive push controller sitting between the link-layer RX datapath and the
// per-channel RX FIFOs. For every channel it:
//   - qualifies the upstream push request with link-online and the channel
//     override, optionally delaying it one cycle to line up with the data path;
//   - shadows the FIFO occupancy from the accepted pushes and the FIFO pops,
//     suppressing (and flagging) pushes into a full FIFO;
//   - keeps sticky overflow/underflow flags and a saturating push counter.
//
// Ports
//   clk_wr          in   clock, all state updates on the rising edge
//   rst_wr          in   synchronous active-high reset
//   rx_online       in   link online; low blocks every push
//   rx_i_push_ovrd  in   [NUM_CH] per-channel override, 1 blocks the channel
//   rx_i_pushbit    in   [NUM_CH] upstream push request
//   rxfifo_i_pop    in   [NUM_CH] FIFO pop strobe
//   rxfifo_i_push   out  [NUM_CH] push strobe to the FIFO
//   rx_fifo_level   out  [NUM_CH*LVL_W] occupancy, channel 0 in the LSBs
//   rx_fifo_full    out  [NUM_CH] occupancy equals DEPTH
//   rx_overflow     out  [NUM_CH] sticky, a push was dropped because full
//   rx_underflow    out  [NUM_CH] sticky, a pop arrived while empty
//   rx_status_clr   in   clears both sticky flag vectors
//   rx_push_cnt     out  [NUM_CH*CNT_W] saturating accepted-push count
// ---------------------------------------------------------------------------
module ll_rx_push_ctl #(
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 8,
    parameter int PUSH_REG = 1,
    parameter int CNT_W    = 16,
    localparam int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk_wr,
    input  logic                      rst_wr,
    input  logic                      rx_online,
    input  logic [NUM_CH-1:0]         rx_i_push_ovrd,
    input  logic [NUM_CH-1:0]         rx_i_pushbit,
    input  logic [NUM_CH-1:0]         rxfifo_i_pop,
    output logic [NUM_CH-1:0]         rxfifo_i_push,
    output logic [NUM_CH*LVL_W-1:0]   rx_fifo_level,
    output logic [NUM_CH-1:0]         rx_fifo_full,
    output logic [NUM_CH-1:0]         rx_overflow,
    output logic [NUM_CH-1:0]         rx_underflow,
    input  logic                      rx_status_clr,
    output logic [NUM_CH*CNT_W-1:0]   rx_push_cnt
);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [NUM_CH-1:0][LVL_W-1:0] lvl_q, lvl_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]            ovf_q, ovf_d;
    logic [NUM_CH-1:0]            udf_q, udf_d;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] pop_ok;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] drop;

    assign req = rx_i_pushbit & ~rx_i_push_ovrd & {NUM_CH{rx_online}};

    // Optional one-cycle alignment stage. The staged request is re-gated
    // with the current online bit so a link drop during the delay cycle
    // kills the push.
    if (PUSH_REG != 0) begin : g_stage
        logic [NUM_CH-1:0] stg_q;

        always_ff @(posedge clk_wr) begin
            if (rst_wr) begin
                stg_q <= '0;
            end else begin
                stg_q <= req;
            end
        end

        assign cand = stg_q & {NUM_CH{rx_online}};
    end else begin : g_nostage
        assign cand = req;
    end

    always_comb begin
        full   = '0;
        pop_ok = '0;
        push   = '0;
        drop   = '0;
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]   = (lvl_q[c] == DEPTH_L);
            pop_ok[c] = rxfifo_i_pop[c] & (lvl_q[c] != '0);
            // A pop in the same cycle frees the slot, so a full FIFO can
            // still take a push. Reset masks the strobe even in the
            // combinational configuration.
            push[c]   = cand[c] & (~full[c] | pop_ok[c]) & ~rst_wr;
            drop[c]   = cand[c] & full[c] & ~pop_ok[c];

            case ({push[c], pop_ok[c]})
                2'b10:   lvl_d[c] = lvl_q[c] + LVL_W'(1);
                2'b01:   lvl_d[c] = lvl_q[c] - LVL_W'(1);
                default: lvl_d[c] = lvl_q[c];
            endcase

            if (push[c]) begin
                cnt_d[c] = sat_inc(cnt_q[c]);
            end

            // A set event in the clear cycle wins over the clear.
            ovf_d[c] = drop[c] | (ovf_q[c] & ~rx_status_clr);
            udf_d[c] = (rxfifo_i_pop[c] & (lvl_q[c] == '0))
                     | (udf_q[c] & ~rx_status_clr);
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            lvl_q <= '0;
            cnt_q <= '0;
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign rxfifo_i_push = push;
    assign rx_fifo_level = lvl_q;
    assign rx_fifo_full  = full;
    assign rx_overflow   = ovf_q;
    assign rx_underflow  = udf_q;
    assign rx_push_cnt   = cnt_q;

endmodule

// File: tb/tb_ll_rx_push_ctl.sv
// ---------------------------------------------------------------------------
// tb_ll_rx_push_ctl
//
// Drives two instances of ll_rx_push_ctl from the same stimulus: one with the
// combinational push path and one with the registered push path, both with a
// 4-bit push counter so saturation is reachable. A per-channel integer model
// of occupancy, sticky flags and counters predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_ll_rx_push_ctl;

    localparam int NCH   = 4;
    localparam int DEP   = 8;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEP + 1);
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, online, clr;
    logic [NCH-1:0] ovrd, pb, pop;

    logic [NCH-1:0]    push0, full0, ovf0, udf0;
    logic [NCH*LW-1:0] lvl0;
    logic [NCH*CW-1:0] cnt0;
    logic [NCH-1:0]    push1, full1, ovf1, udf1;
    logic [NCH*LW-1:0] lvl1;
    logic [NCH*CW-1:0] cnt1;

    ll_rx_push_ctl #(.NUM_CH(NCH), .DEPTH(DEP), .PUSH_REG(0), .CNT_W(CW)) u_comb (
        .clk_wr(clk), .rst_wr(rst), .rx_online(online),
        .rx_i_push_ovrd(ovrd), .rx_i_pushbit(pb), .rxfifo_i_pop(pop),
        .rxfifo_i_push(push0), .rx_fifo_level(lvl0), .rx_fifo_full(full0),
        .rx_overflow(ovf0), .rx_underflow(udf0), .rx_status_clr(clr),
        .rx_push_cnt(cnt0)
    );

    ll_rx_push_ctl #(.NUM_CH(NCH), .DEPTH(DEP), .PUSH_REG(1), .CNT_W(CW)) u_reg (
        .clk_wr(clk), .rst_wr(rst), .rx_online(online),
        .rx_i_push_ovrd(ovrd), .rx_i_pushbit(pb), .rxfifo_i_pop(pop),
        .rxfifo_i_push(push1), .rx_fifo_level(lvl1), .rx_fifo_full(full1),
        .rx_overflow(ovf1), .rx_underflow(udf1), .rx_status_clr(clr),
        .rx_push_cnt(cnt1)
    );

    // Reference state, index [instance][channel]; instance 1 is registered.
    int m_lvl [2][NCH];
    int m_cnt [2][NCH];
    bit m_ovf [2][NCH];
    bit m_udf [2][NCH];
    bit m_stg [2][NCH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < NCH; c++) begin
                m_lvl[i][c] = 0; m_cnt[i][c] = 0;
                m_ovf[i][c] = 0; m_udf[i][c] = 0; m_stg[i][c] = 0;
            end
    endtask

    // One clock cycle: apply inputs, check every output against the model,
    // then advance the model across the rising edge.
    task automatic cyc(input bit r, input bit on, input logic [NCH-1:0] ov,
                       input logic [NCH-1:0] p, input logic [NCH-1:0] pp,
                       input bit cl);
        bit e_push [2][NCH];
        bit e_cand [2][NCH];
        bit e_pok  [2][NCH];
        logic [63:0] x_push, x_lvl, x_full, x_ovf, x_udf, x_cnt;
        @(negedge clk);
        rst = r; online = on; ovrd = ov; pb = p; pop = pp; clr = cl;
        #1;
        for (int i = 0; i < 2; i++) begin
            x_push = 0; x_lvl = 0; x_full = 0; x_ovf = 0; x_udf = 0; x_cnt = 0;
            for (int c = 0; c < NCH; c++) begin
                bit rq;
                rq = p[c] && !ov[c] && on;
                e_cand[i][c] = (i == 1) ? (m_stg[i][c] && on) : rq;
                e_pok[i][c]  = pp[c] && (m_lvl[i][c] > 0);
                e_push[i][c] = !r && e_cand[i][c] && ((m_lvl[i][c] < DEP) || e_pok[i][c]);
                x_push[c] = e_push[i][c];
                x_full[c] = (m_lvl[i][c] == DEP);
                x_ovf[c]  = m_ovf[i][c];
                x_udf[c]  = m_udf[i][c];
                x_lvl     = x_lvl | (64'(m_lvl[i][c]) << (c * LW));
                x_cnt     = x_cnt | (64'(m_cnt[i][c]) << (c * CW));
            end
            if (i == 0) begin
                chk("push_comb", 64'(push0), x_push);
                chk("level_comb", 64'(lvl0), x_lvl);
                chk("full_comb", 64'(full0), x_full);
                chk("ovf_comb", 64'(ovf0), x_ovf);
                chk("udf_comb", 64'(udf0), x_udf);
                chk("cnt_comb", 64'(cnt0), x_cnt);
            end else begin
                chk("push_reg", 64'(push1), x_push);
                chk("level_reg", 64'(lvl1), x_lvl);
                chk("full_reg", 64'(full1), x_full);
                chk("ovf_reg", 64'(ovf1), x_ovf);
                chk("udf_reg", 64'(udf1), x_udf);
                chk("cnt_reg", 64'(cnt1), x_cnt);
            end
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < NCH; c++) begin
                    bit drop, empty_pop;
                    drop      = e_cand[i][c] && (m_lvl[i][c] == DEP) && !e_pok[i][c];
                    empty_pop = pp[c] && (m_lvl[i][c] == 0);
                    m_lvl[i][c] = m_lvl[i][c] + int'(e_push[i][c]) - int'(e_pok[i][c]);
                    if (e_push[i][c] && m_cnt[i][c] < CMAX) m_cnt[i][c]++;
                    m_ovf[i][c] = drop || (m_ovf[i][c] && !cl);
                    m_udf[i][c] = empty_pop || (m_udf[i][c] && !cl);
                    m_stg[i][c] = p[c] && !ov[c] && on;
                end
        end
    endtask

    initial begin
        rst = 1'b1; online = 1'b0; clr = 1'b0; ovrd = '0; pb = '0; pop = '0;
        model_reset();

        // Reset with requests present: strobes must stay low.
        cyc(1, 1, 4'h0, 4'hF, 4'h0, 0);
        cyc(1, 1, 4'h0, 4'hF, 4'h0, 0);

        // Basic push on ch0/ch2.
        cyc(0, 1, 4'h0, 4'h5, 4'h0, 0);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 0);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 0);

        // Override gating, and online dropping during the stage cycle.
        cyc(0, 1, 4'h1, 4'h3, 4'h0, 0);
        cyc(0, 0, 4'h1, 4'h0, 4'h0, 0);
        cyc(0, 1, 4'h1, 4'h3, 4'h0, 0);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 0);

        // Fill ch0 past full.
        for (int k = 0; k < 10; k++) cyc(0, 1, 4'h0, 4'h1, 4'h0, 0);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 0);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 0);

        // Push and pop together at full.
        cyc(0, 1, 4'h0, 4'h1, 4'h1, 0);
        cyc(0, 1, 4'h0, 4'h0, 4'h1, 0);

        // Clear racing a new overflow, then clear alone.
        cyc(0, 1, 4'h0, 4'h1, 4'h0, 1);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 1);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 0);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 1);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 0);

        // Drain everything and pop past empty.
        for (int k = 0; k < 12; k++) cyc(0, 1, 4'h0, 4'h0, 4'hF, 0);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 0);

        // Counter saturation with continuous push and pop.
        for (int k = 0; k < 22; k++) cyc(0, 1, 4'h0, 4'hF, 4'hF, 0);

        // Reset in the middle of a burst discards the staged request.
        cyc(0, 1, 4'h0, 4'hF, 4'h0, 0);
        cyc(1, 1, 4'h0, 4'hF, 4'h0, 0);
        cyc(0, 1, 4'h0, 4'h0, 4'h0, 0);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            logic [NCH-1:0] rp, rpop, rov;
            bit ron, rcl, rr;
            rp   = NCH'($urandom);
            rpop = NCH'($urandom) & NCH'($urandom);
            rov  = (($urandom % 8) == 0) ? NCH'($urandom) : '0;
            ron  = (($urandom % 12) != 0);
            rcl  = (($urandom % 20) == 0);
            rr   = (($urandom % 200) == 0);
            cyc(rr, ron, rov, rp, rpop, rcl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ll_rx_push_ctl.md
Name: ll_rx_push_ctl

Overview:
Multi-channel receive push controller between the link-layer RX datapath and the per-channel RX FIFOs. Per channel it qualifies the upstream push bit with link-online and per-channel override, and optionally registers it to match a one-cycle-delayed data path. It tracks FIFO occupancy against the FIFO pop so pushes into a full FIFO are suppressed and flagged. It also keeps sticky overflow/underflow status and saturating push counters for debug.

Parameters:
NUM_CH, 4, number of independent receive channels (1..16)
DEPTH, 8, entries per channel FIFO (2..256)
PUSH_REG, 1, 0 = push output combinational from inputs; 1 = push output registered (+1 cycle)
CNT_W, 16, width of per-channel saturating push counter
LVL_W, $clog2(DEPTH+1), occupancy width (derived; not overridden)

Ports:
clk_wr  in  1  clock; all logic on rising edge
rst_wr  in  1  synchronous, active-high reset
rx_online  in  1  link online; 0 blocks all pushes
rx_i_push_ovrd  in  NUM_CH  per-channel push override; 1 blocks that channel
rx_i_pushbit  in  NUM_CH  upstream push request per channel
rxfifo_i_pop  in  NUM_CH  FIFO pop per channel (same clock)
rxfifo_i_push  out  NUM_CH  push strobe to FIFO
rx_fifo_level  out  NUM_CH*LVL_W  per-channel occupancy, ch0 in LSBs
rx_fifo_full  out  NUM_CH  level == DEPTH
rx_overflow  out  NUM_CH  sticky: push dropped because full
rx_underflow  out  NUM_CH  sticky: pop seen while level == 0
rx_status_clr  in  1  clears rx_overflow and rx_underflow (all channels)
rx_push_cnt  out  NUM_CH*CNT_W  saturating count of accepted pushes, ch0 in LSBs

Behaviour:
- Reset (rst_wr=1 at edge): all levels 0, full 0, overflow/underflow 0, counters 0, push stage 0; rxfifo_i_push=0 during and after reset until a qualified request.
- Qualify: req[c] = rx_i_pushbit[c] & !rx_i_push_ovrd[c] & rx_online.
- Stage: PUSH_REG=0 -> cand[c]=req[c] same cycle. PUSH_REG=1 -> stg[c] <= req[c] each cycle; cand[c] = stg[c] & rx_online (stage killed if online drops during the delay cycle).
- Pop: pop_ok[c] = rxfifo_i_pop[c] & (level[c] != 0). Pop with level 0 -> ignored, rx_underflow[c] set.
- Accept: rxfifo_i_push[c] = cand[c] & (level[c] < DEPTH | pop_ok[c]). Full with simultaneous pop -> push accepted, level unchanged.
- Drop: cand[c] & level==DEPTH & !pop_ok[c] -> rxfifo_i_push[c]=0, rx_overflow[c] set next cycle.
- Level: level <= level + push - pop_ok; never exceeds DEPTH, never below 0; push+pop same cycle -> unchanged.
- rx_fifo_full registered-equivalent: derived from level register (no combinational path from inputs).
- Sticky clear: rx_status_clr=1 clears flags; a set event in the same cycle wins (flag stays/becomes 1).
- Counter: increments on each rxfifo_i_push[c]; holds at 2^CNT_W-1; cleared only by reset.
- rx_online=0 does not clear levels (FIFO contents persist); pops still processed.
- Channels fully independent; no cross-channel arbitration.

Test Plan:
- Reset/basic: NUM_CH=4, PUSH_REG=0, online=1, pushbit=4'b0101 one cycle -> rxfifo_i_push=4'b0101 same cycle; levels ch0=1, ch2=1 next cycle; push_cnt ch0=1.
- Gating/latency: PUSH_REG=1, ovrd=4'b0001, pushbit=4'b0011 at cycle t -> rxfifo_i_push=4'b0010 at t+1 only; drop rx_online at t+1 -> no push at t+1, ch1 level stays 0.
- Full/overflow: DEPTH=8, push ch0 10 consecutive cycles, no pop -> 8 pushes accepted, level=8, full=1, rx_overflow[0]=1 after 9th request; push_cnt=8.
- Full with pop: level=8, push+pop same cycle -> push accepted, level stays 8, no overflow; pop-only at level 0 -> rx_underflow=1, level 0.
- Sticky clear race: rx_status_clr=1 in same cycle as new overflow event -> rx_overflow stays 1; clear alone next cycle -> 0.
- Saturation/reset mid-op: CNT_W=4, 20 accepted pushes with pops -> counter holds 15; assert rst_wr mid-burst -> all outputs 0 next cycle, staged push discarded.
